// File: rtl/dma_pkg.sv
// Shared definitions for the DMA I/O device: FSM state encoding and transfer direction.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dma_pkg;

  // Channel FSM. REQ asks the controller for the bus; XFER is the DACK window.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } dmaState_t;

  // Transfer direction as seen from memory.
  localparam logic DIR_SOURCE = 1'b0; // device -> memory, controller reads with IOR_N
  localparam logic DIR_SINK   = 1'b1; // memory -> device, controller writes with IOW_N

  // True on the cycle an active-low strobe is released (previous low, now high).
  function automatic logic strobeReleased(input logic prevLevel, input logic curLevel);
    return !prevLevel && curLevel;
  endfunction

endpackage

// File: rtl/dma_io_device_if.sv
// System-bus side of the DMA I/O device: request/acknowledge, strobes and data bus.
// Latency: n/a (wires only).
// Backpressure: n/a; the controller paces transfers with DACK and the strobes.
// Ports (signals): DREQ, DACK, IOR_N, IOW_N, EOP_N, DB_IN[DW], DB_OUT[DW], DB_OE.
interface dma_io_device_if #(
  parameter int DW = 8
);

  logic          DREQ;
  logic          DACK;
  logic          IOR_N;
  logic          IOW_N;
  logic          EOP_N;
  logic [DW-1:0] DB_IN;
  logic [DW-1:0] DB_OUT;
  logic          DB_OE;

  // DMA controller side.
  modport master (
    input  DREQ, DB_OUT, DB_OE,
    output DACK, IOR_N, IOW_N, EOP_N, DB_IN
  );

  // Device side.
  modport slave (
    output DREQ, DB_OUT, DB_OE,
    input  DACK, IOR_N, IOW_N, EOP_N, DB_IN
  );

endinterface

// File: rtl/dma_byte_fifo.sv
// Circular FIFO of DEPTH words of DW bits with a combinational head output.
// Latency: write visible at head one cycle after push into an empty FIFO.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
// Ports: clk, rst, push/pushData, pop/popData (head), count, full, empty.
module dma_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            pushData,
  input  logic                     pop,
  output logic [DW-1:0]            popData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign popData = mem[rdPtr];

  // A pop frees the head slot in the same cycle, so a full FIFO can still
  // accept a simultaneous push; the write lands after the head is consumed.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_io_device.sv
// Single-channel DMA peripheral: buffers bytes between a local stream port and a DMA bus.
// Latency: DREQ one cycle after the FIFO becomes eligible; bus pop/push on strobe release.
// Backpressure: push_ready drops when full (source); DREQ withheld while full (sink) or empty (source).
// Ports: CLK, RESET, bus (DREQ/DACK/IOR_N/IOW_N/EOP_N/DB_*), enable, dir,
//        push_valid/push_data/push_ready, pop_valid/pop_data/pop_ready, count, done, underrun, overrun.
module dma_io_device
  import dma_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  dma_io_device_if.slave         bus,
  input  logic                   enable,
  input  logic                   dir,
  input  logic                   push_valid,
  input  logic [DW-1:0]          push_data,
  output logic                   push_ready,
  output logic                   pop_valid,
  output logic [DW-1:0]          pop_data,
  input  logic                   pop_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   done,
  output logic                   underrun,
  output logic                   overrun
);

  dmaState_t     state;
  dmaState_t     nextState;
  logic          dirQ;
  logic          dirEff;
  logic          iorPrev;
  logic          iowPrev;
  logic          dackQ;
  logic          eopQ;
  logic          enableQ;
  logic          inDoneQ;

  logic          strobeOk;
  logic          iorRise;
  logic          iowRise;
  logic          localPush;
  logic          localPop;
  logic          fifoPush;
  logic          fifoPop;
  logic [DW-1:0] fifoPushData;
  logic [DW-1:0] head;
  logic          fifoFull;
  logic          fifoEmpty;
  logic          setUnderrun;
  logic          setOverrun;
  logic          busOe;

  // Direction follows the input while idle and is frozen for the whole transfer.
  assign dirEff = (state == IDLE) ? dir : dirQ;

  // A strobe counts only if DACK was held while it was low; dackQ covers the
  // release cycle, which may coincide with the controller dropping DACK.
  assign strobeOk = (state == XFER) && dackQ;
  assign iorRise  = strobeOk && (dirQ == DIR_SOURCE) && strobeReleased(iorPrev, bus.IOR_N);
  assign iowRise  = strobeOk && (dirQ == DIR_SINK)   && strobeReleased(iowPrev, bus.IOW_N);

  assign push_ready = (dirEff == DIR_SOURCE) && !fifoFull;
  assign pop_valid  = (dirEff == DIR_SINK) && !fifoEmpty;
  assign pop_data   = head;
  assign localPush  = push_valid && push_ready;
  assign localPop   = pop_valid && pop_ready;

  // Only one producer and one consumer are live for a given direction.
  assign fifoPush     = localPush || iowRise;
  assign fifoPushData = iowRise ? bus.DB_IN : push_data;
  assign fifoPop      = localPop || iorRise;

  assign setUnderrun = iorRise && fifoEmpty;
  assign setOverrun  = iowRise && fifoFull && !localPop;

  dma_byte_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RESET),
    .push     (fifoPush),
    .pushData (fifoPushData),
    .pop      (fifoPop),
    .popData  (head),
    .count    (count),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Bus drive: head word during a qualified read strobe, all-ones if nothing to give.
  assign busOe      = (state == XFER) && (dirQ == DIR_SOURCE) && bus.DACK && !bus.IOR_N;
  assign bus.DB_OE  = busOe;
  assign bus.DB_OUT = !busOe ? '0 : (fifoEmpty ? '1 : head);

  // Gated with enable so a request withdrawn in REQ disappears the same cycle.
  assign bus.DREQ = (state == REQ) && enable;

  assign done = (state == DONE) && !inDoneQ;

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (enable && (((dirEff == DIR_SOURCE) && !fifoEmpty) ||
                       ((dirEff == DIR_SINK) && !fifoFull))) begin
          nextState = REQ;
        end
      end
      REQ: begin
        if (!enable) begin
          nextState = IDLE;
        end else if (bus.DACK) begin
          nextState = XFER;
        end
      end
      XFER: begin
        // XFER is entered with DACK high, so any low sample is the falling edge.
        if (!bus.DACK) begin
          nextState = (eopQ || !bus.EOP_N) ? DONE : IDLE;
        end
      end
      DONE: begin
        if (!enable) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      dirQ     <= DIR_SOURCE;
      iorPrev  <= 1'b1;
      iowPrev  <= 1'b1;
      dackQ    <= 1'b0;
      eopQ     <= 1'b0;
      enableQ  <= 1'b0;
      inDoneQ  <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state   <= nextState;
      if (state == IDLE) begin
        dirQ <= dir;
      end
      iorPrev <= bus.IOR_N;
      iowPrev <= bus.IOW_N;
      dackQ   <= bus.DACK;
      eopQ    <= (state == XFER) && (eopQ || !bus.EOP_N);
      enableQ <= enable;
      inDoneQ <= (state == DONE);

      // Error flags are sticky until the channel is re-enabled.
      if (enable && !enableQ) begin
        underrun <= 1'b0;
        overrun  <= 1'b0;
      end else begin
        if (setUnderrun) begin
          underrun <= 1'b1;
        end
        if (setOverrun) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_io_device.sv
// Directed bench for dma_io_device: source, sink, EOP, error and reset scenarios.
// Latency: inputs driven 1ns after the rising edge, outputs checked before the next edge.
// Backpressure: exercised through a full sink FIFO and an empty source FIFO.
module tb_dma_io_device;
  import dma_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 8;

  logic                   CLK = 1'b0;
  logic                   RESET;
  logic                   enable;
  logic                   dir;
  logic                   push_valid;
  logic [DW-1:0]          push_data;
  logic                   push_ready;
  logic                   pop_valid;
  logic [DW-1:0]          pop_data;
  logic                   pop_ready;
  logic [$clog2(DEPTH):0] count;
  logic                   done;
  logic                   underrun;
  logic                   overrun;

  int errors = 0;
  int checks = 0;

  dma_io_device_if #(.DW(DW)) bus ();

  dma_io_device #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .bus        (bus),
    .enable     (enable),
    .dir        (dir),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .pop_ready  (pop_ready),
    .count      (count),
    .done       (done),
    .underrun   (underrun),
    .overrun    (overrun)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET      = 1'b0;
    enable     = 1'b0;
    dir        = DIR_SOURCE;
    push_valid = 1'b0;
    push_data  = '0;
    pop_ready  = 1'b0;
    bus.DACK   = 1'b0;
    bus.IOR_N  = 1'b1;
    bus.IOW_N  = 1'b1;
    bus.EOP_N  = 1'b1;
    bus.DB_IN  = '0;

    // Reset state
    #2 RESET = 1'b1;
    #1;
    check("rst_dreq",     32'(bus.DREQ),   32'h0);
    check("rst_oe",       32'(bus.DB_OE),  32'h0);
    check("rst_dbout",    32'(bus.DB_OUT), 32'h0);
    check("rst_count",    32'(count),      32'h0);
    check("rst_done",     32'(done),       32'h0);
    check("rst_underrun", 32'(underrun),   32'h0);
    check("rst_overrun",  32'(overrun),    32'h0);
    step(2);
    RESET = 1'b0;
    step(1);

    // Source: two local pushes raise DREQ, one IOR pops the head
    enable     = 1'b1;
    push_valid = 1'b1;
    push_data  = 8'h11;
    check("src_push_ready", 32'(push_ready), 32'h1);
    step(1);
    push_data = 8'h22;
    step(1);
    push_valid = 1'b0;
    check("src_count2", 32'(count),    32'h2);
    check("src_dreq",   32'(bus.DREQ), 32'h1);
    bus.DACK = 1'b1;
    step(1);
    check("src_dreq_low", 32'(bus.DREQ),  32'h0);
    check("src_oe_idle",  32'(bus.DB_OE), 32'h0);
    bus.IOR_N = 1'b0;
    #1;
    check("src_oe_strobe", 32'(bus.DB_OE),  32'h1);
    check("src_dbout",     32'(bus.DB_OUT), 32'h11);
    step(1);
    check("src_count_hold", 32'(count), 32'h2);
    bus.IOR_N = 1'b1;
    step(1);
    check("src_count1",    32'(count),      32'h1);
    check("src_oe_after",  32'(bus.DB_OE),  32'h0);
    check("src_dbout_off", 32'(bus.DB_OUT), 32'h0);

    // EOP during the second read, then DACK falls
    bus.IOR_N = 1'b0;
    bus.EOP_N = 1'b0;
    #1;
    check("eop_dbout", 32'(bus.DB_OUT), 32'h22);
    step(1);
    bus.EOP_N = 1'b1;
    bus.IOR_N = 1'b1;
    step(1);
    check("eop_count0", 32'(count), 32'h0);
    bus.DACK = 1'b0;
    step(1);
    check("eop_state_done", 32'(dut.state), 32'(DONE));
    check("eop_done_pulse", 32'(done),      32'h1);
    step(1);
    check("eop_done_clear", 32'(done),      32'h0);
    check("eop_state_hold", 32'(dut.state), 32'(DONE));
    step(1);
    check("eop_done_still0", 32'(done), 32'h0);
    enable = 1'b0;
    step(1);
    check("eop_state_idle", 32'(dut.state), 32'(IDLE));

    // Underrun: read with the FIFO already drained
    enable     = 1'b1;
    push_valid = 1'b1;
    push_data  = 8'h33;
    step(1);
    push_valid = 1'b0;
    step(1);
    bus.DACK = 1'b1;
    step(1);
    bus.IOR_N = 1'b0;
    step(1);
    bus.IOR_N = 1'b1;
    step(1);
    check("und_count0", 32'(count), 32'h0);
    bus.IOR_N = 1'b0;
    #1;
    check("und_oe",    32'(bus.DB_OE),  32'h1);
    check("und_dbout", 32'(bus.DB_OUT), 32'hFF);
    step(1);
    bus.IOR_N = 1'b1;
    step(1);
    check("und_flag",  32'(underrun), 32'h1);
    check("und_count", 32'(count),    32'h0);
    bus.DACK = 1'b0;
    step(1);
    enable = 1'b0;
    step(1);
    check("und_sticky", 32'(underrun), 32'h1);
    enable = 1'b1;
    step(1);
    check("und_cleared", 32'(underrun), 32'h0);

    // Sink: one IOW write lands in the FIFO
    dir = DIR_SINK;
    step(1);
    check("snk_dreq",       32'(bus.DREQ),  32'h1);
    check("snk_push_ready", 32'(push_ready), 32'h0);
    check("snk_pop_valid0", 32'(pop_valid),  32'h0);
    bus.DACK = 1'b1;
    step(1);
    bus.DB_IN = 8'hA5;
    bus.IOW_N = 1'b0;
    step(1);
    check("snk_oe", 32'(bus.DB_OE), 32'h0);
    bus.IOW_N = 1'b1;
    step(1);
    check("snk_pop_valid", 32'(pop_valid), 32'h1);
    check("snk_pop_data",  32'(pop_data),  32'hA5);
    check("snk_count1",    32'(count),     32'h1);

    // Fill to DEPTH, then one more write overruns
    for (int i = 1; i <= 7; i++) begin
      bus.DB_IN = 8'(i);
      bus.IOW_N = 1'b0;
      step(1);
      bus.IOW_N = 1'b1;
      step(1);
    end
    check("ovr_count_full", 32'(count), 32'h8);
    bus.DB_IN = 8'hEE;
    bus.IOW_N = 1'b0;
    step(1);
    bus.IOW_N = 1'b1;
    step(1);
    check("ovr_flag",  32'(overrun),  32'h1);
    check("ovr_count", 32'(count),    32'h8);
    check("ovr_head",  32'(pop_data), 32'hA5);

    // Local pop, then a DMA write and local pop in the same cycle
    bus.DACK = 1'b0;
    step(1);
    pop_ready = 1'b1;
    step(1);
    pop_ready = 1'b0;
    check("pop_count7", 32'(count),    32'h7);
    check("pop_head",   32'(pop_data), 32'h01);
    step(1);
    check("pop_dreq", 32'(bus.DREQ), 32'h1);
    bus.DACK = 1'b1;
    step(1);
    bus.DB_IN = 8'h5A;
    bus.IOW_N = 1'b0;
    step(1);
    bus.IOW_N = 1'b1;
    pop_ready = 1'b1;
    step(1);
    pop_ready = 1'b0;
    check("both_count", 32'(count),    32'h7);
    check("both_head",  32'(pop_data), 32'h02);
    check("both_ovr",   32'(overrun),  32'h1);

    // Reset in the middle of a read strobe
    dir      = DIR_SOURCE;
    bus.DACK = 1'b0;
    step(1);
    step(1);
    bus.DACK = 1'b1;
    step(1);
    bus.IOR_N = 1'b0;
    #1;
    check("mid_oe",    32'(bus.DB_OE),  32'h1);
    check("mid_dbout", 32'(bus.DB_OUT), 32'h02);
    #2 RESET = 1'b1;
    #1;
    check("mid_rst_dreq",  32'(bus.DREQ),  32'h0);
    check("mid_rst_oe",    32'(bus.DB_OE), 32'h0);
    check("mid_rst_count", 32'(count),     32'h0);
    check("mid_rst_ovr",   32'(overrun),   32'h0);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    step(1);
    RESET      = 1'b0;
    bus.DACK   = 1'b0;
    enable     = 1'b1;
    push_valid = 1'b1;
    push_data  = 8'h77;
    step(1);
    push_valid = 1'b0;
    bus.IOR_N  = 1'b1;
    step(1);
    check("post_rst_count", 32'(count),    32'h1);
    check("post_rst_und",   32'(underrun), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_io_device.md
DMA_IO_DEVICE -- requirements
Module: dma_io_device

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter DW, default 8, data bus width.
REQ-003 SHALL have ports:
- CLK  in  1  single clock, shared with DMA controller.
- RESET  in  1  asynchronous, active-high.
- DREQ  out  1  DMA request to controller.
- DACK  in  1  DMA acknowledge, active-high.
- IOR_N  in  1  controller I/O read strobe, active-low.
- IOW_N  in  1  controller I/O write strobe, active-low.
- EOP_N  in  1  end-of-process from controller, active-low.
- DB_IN  in  DW  system data bus, inbound.
- DB_OUT  out  DW  system data bus, outbound.
- DB_OE  out  1  DB_OUT drive enable.
- enable  in  1  local channel enable.
- dir  in  1  0 = source (device to memory, IOR), 1 = sink (memory to device, IOW).
- push_valid / push_data[DW] / push_ready  in/in/out  local write side (source mode).
- pop_valid / pop_data[DW] / pop_ready  out/out/in  local read side (sink mode).
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- done  out  1  one-cycle pulse on EOP completion.
- underrun, overrun  out  1  sticky error flags.
REQ-004 All inputs SHALL be synchronous to CLK; reset is asynchronous, active-high, fixed.

Function
REQ-005 SHALL hold one DEPTH-entry FIFO; dir selects which side pushes and which pops; dir SHALL be sampled only in IDLE.
REQ-006 FSM states: IDLE, REQ, XFER, DONE.
REQ-007 IDLE->REQ when enable=1 and (dir=0 and count>=1) or (dir=1 and count<DEPTH).
REQ-008 DREQ SHALL be 1 only in REQ; REQ->XFER on the cycle DACK is sampled 1 (DREQ low the following cycle).
REQ-009 Source, XFER: while DACK=1 and IOR_N=0, DB_OE=1, DB_OUT=FIFO head (combinational from head register); pop on IOR_N 0->1 edge (registered previous value).
REQ-010 Sink, XFER: capture DB_IN into FIFO on IOW_N 0->1 edge while DACK=1.
REQ-011 DB_OE SHALL be 0 in every other condition; DB_OUT=0 when DB_OE=0.
REQ-012 EOP_N sampled 0 at any point in XFER SHALL be latched; on DACK 1->0 go DONE if latched, else IDLE.
REQ-013 DONE: done=1 for its first cycle only; DONE->IDLE when enable=0.
REQ-014 enable=0 during XFER SHALL let the current strobe finish; return to IDLE at DACK fall; enable=0 in REQ -> IDLE immediately, DREQ 0.
REQ-015 IOR with FIFO empty: DB_OUT=all-ones, no pop, underrun set.
REQ-016 IOW with FIFO full: data dropped, overrun set.
REQ-017 Local push and DMA pop (or DMA push and local pop) in the same cycle: both occur, count unchanged.
REQ-018 push_ready = (dir=0 and count<DEPTH); pop_valid = (dir=1 and count>0); pointers wrap modulo DEPTH.
REQ-019 Errors SHALL clear only on RESET or enable 0->1.
REQ-020 Strobes without DACK=1 SHALL be ignored.

Reset
REQ-021 RESET SHALL force IDLE, DREQ=0, DB_OE=0, DB_OUT=0, count=0, pointers=0, done=0, underrun=0, overrun=0, EOP latch=0, edge registers=1 (strobes inactive), including mid-transfer.

Structure
REQ-022 State enum and DIR_SOURCE/DIR_SINK constants SHALL live in shared package dma_pkg.
REQ-023 FIFO SHALL be sub-module dma_byte_fifo (DEPTH, DW; push/pop/count/full/empty).

Verification
REQ-024 Source: push 0x11,0x22 -> DREQ=1; DACK=1 -> DREQ=0; IOR pulse -> DB_OUT=0x11, DB_OE=1 during strobe, count 2->1.
REQ-025 Sink: DACK, IOW with DB_IN=0xA5 -> pop_valid=1, pop_data=0xA5, count=1.
REQ-026 EOP_N=0 during IOR transfer, DACK falls -> done=1 exactly one cycle, state DONE until enable=0.
REQ-027 Source empty, forced IOR with DACK -> DB_OUT=0xFF, underrun=1, count stays 0; sink full (8 entries), IOW -> overrun=1, count stays 8.
REQ-028 RESET asserted mid-IOR strobe -> DREQ=0, DB_OE=0, count=0 asynchronously; IOR rising after reset causes no pop.
